safe_lock_ctrl: RTL and testbench
=================================

// Module: safe_lock_ctrl
// PURPOSE
//  Combination-lock controller for the safe design. Takes debounced single-cycle button
//  pulses, builds an N-digit code one digit at a time and compares it with a stored code.
//  Sequences three states: entry, open and alarm lockout.
//  Drives the digit/position/try values shown on the 7-seg display and the unlock/alarm LEDs.
// PARAMETERS
//  N_DIGITS     3              code length, legal range 1..4
//  CODE         12'h753        stored code, 4 bits per digit; digit0 = CODE[3:0] is entered first
//  MAX_TRIES    3              failed attempts before lockout, legal range 1..3
//  LOCKOUT_CYC  100_000_000    lockout duration in CLK cycles
//  RELOCK_CYC   500_000_000    auto-relock delay in CLK cycles (only with SAFE_LOCK_AUTORELOCK_EN)
// PORTS
//  CLK       in   1  system clock, all logic on posedge
//  BTNR      in   1  asynchronous active-high reset
//  step      in   1  1-cycle pulse: increment current digit
//  enter     in   1  1-cycle pulse: commit current digit
//  lock      in   1  1-cycle pulse: relock from OPEN
//  dig       out  4  current digit value being edited, 0..9
//  idx       out  2  position of digit being edited, 0..N_DIGITS-1
//  tries     out  2  failed attempts since last unlock/lockout
//  state     out  2  00=ENTRY 01=OPEN 10=LOCKOUT
//  unlocked  out  1  high while in OPEN
//  alarm     out  1  high while in LOCKOUT
// BEHAVIOUR
//  Reset (BTNR=1, async): all outputs 0, state=ENTRY, internal mismatch flag 0, timers 0.
//  All outputs are registered; each output updates 1 cycle after the causing pulse.
//  ENTRY:
//   - step: dig <= (dig==9) ? 0 : dig+1 (decimal wrap).
//   - enter: mismatch <= mismatch | (dig != CODE[4*idx+:4]); dig <= 0.
//   - enter with idx < N_DIGITS-1: idx <= idx+1.
//   - enter with idx == N_DIGITS-1: idx <= 0, mismatch <= 0, then:
//     * whole code matched: go OPEN, tries <= 0.
//     * otherwise, tries+1 < MAX_TRIES: tries <= tries+1, stay in ENTRY.
//     * otherwise: go LOCKOUT, tries <= MAX_TRIES, load lockout timer.
//   - step and enter in the same cycle: enter wins; the pre-step dig value is committed and the step is dropped.
//  OPEN: unlocked=1; step/enter ignored; lock -> ENTRY, dig=idx=0 next cycle.
//  LOCKOUT: alarm=1 for exactly LOCKOUT_CYC cycles; step/enter/lock ignored.
//   On expiry: go ENTRY, tries <= 0, alarm <= 0.
//  Pulses arriving in the cycle of a state change are ignored.
//  lock in ENTRY/LOCKOUT: no effect.
//  Timers are sized by $clog2 of their limit; no wrap-around is possible.
//  Reset mid-operation (any state, any timer value): immediate return to reset values.
// CONFIGURATION
//  SAFE_LOCK_AUTORELOCK_EN defined:
//   - entering OPEN loads the relock timer.
//   - after RELOCK_CYC cycles in OPEN, go ENTRY automatically (dig=idx=tries=0).
//   - a lock pulse still relocks immediately and cancels the timer.
//  SAFE_LOCK_AUTORELOCK_EN undefined: no relock timer logic; OPEN persists until lock or reset.
// TESTING  (sim with LOCKOUT_CYC=20, RELOCK_CYC=10, defaults otherwise)
//  1. Assert BTNR mid-run -> all outputs 0 and state=00 without waiting for a CLK edge.
//  2. Enter code 3,5,7 (3 steps+enter, 5 steps+enter, 7 steps+enter)
//     -> 1 cycle after last enter: unlocked=1, state=01, tries=0.
//  3. Enter 3,5,6 -> tries=1, idx=0, dig=0, unlocked=0.
//     Enter 0,0,0 next -> tries=2.
//  4. Three wrong codes -> alarm=1 for exactly 20 cycles; step/enter during lockout give no dig/idx change;
//     then state=00, tries=0.
//  5. 10 steps -> dig=0 (wrap). 2 steps, then step+enter together -> digit 2 committed, idx=1.
//  6. From OPEN, no lock -> with macro: state=00 after 10 cycles;
//     without macro: still OPEN after 1000 cycles. A lock pulse relocks in 1 cycle in both builds.

Source files
------------

// File: rtl/safe_lock_ctrl.sv
// Combination-lock controller: builds an N-digit code from step/enter pulses, opens on match,
// locks out after MAX_TRIES failures. Optional auto-relock from OPEN under SAFE_LOCK_AUTORELOCK_EN.
module safe_lock_ctrl #(
  parameter int                    N_DIGITS    = 3,
  parameter logic [4*N_DIGITS-1:0] CODE        = 12'h753,
  parameter int                    MAX_TRIES   = 3,
  parameter int                    LOCKOUT_CYC = 100_000_000,
  parameter int                    RELOCK_CYC  = 500_000_000
) (
  input  logic       CLK,
  input  logic       BTNR,
  input  logic       step,
  input  logic       enter,
  input  logic       lock,
  output logic [3:0] dig,
  output logic [1:0] idx,
  output logic [1:0] tries,
  output logic [1:0] state,
  output logic       unlocked,
  output logic       alarm
);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'b00,
    ST_OPEN    = 2'b01,
    ST_LOCKOUT = 2'b10
  } state_t;

  localparam int          LT_W     = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [LT_W-1:0] LT_LOAD = LT_W'(LOCKOUT_CYC - 1);
  localparam logic [15:0] CODE_EXT = 16'(CODE);
  localparam logic [1:0]  LAST_IDX = 2'(N_DIGITS - 1);
  localparam logic [1:0]  MAX_T    = 2'(MAX_TRIES);
  localparam logic [2:0]  MAX_T3   = 3'(MAX_TRIES);

  if (N_DIGITS < 1 || N_DIGITS > 4) begin : g_bad_n_digits
    $error("safe_lock_ctrl: N_DIGITS must be 1..4");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_bad_max_tries
    $error("safe_lock_ctrl: MAX_TRIES must be 1..3");
  end
  if (LOCKOUT_CYC < 1 || RELOCK_CYC < 1) begin : g_bad_timers
    $error("safe_lock_ctrl: timer limits must be at least 1");
  end

  state_t            state_reg, state_next;
  logic [3:0]        dig_reg, dig_next;
  logic [1:0]        idx_reg, idx_next;
  logic [1:0]        tries_reg, tries_next;
  logic              mismatch_reg, mismatch_next;
  logic [LT_W-1:0]   lock_timer_reg, lock_timer_next;
  logic              unlocked_reg, unlocked_next;
  logic              alarm_reg, alarm_next;
  logic [3:0]        code_digits [4];
  logic              code_bad;

`ifdef SAFE_LOCK_AUTORELOCK_EN
  localparam int              RT_W    = (RELOCK_CYC > 1) ? $clog2(RELOCK_CYC) : 1;
  localparam logic [RT_W-1:0] RT_LOAD = RT_W'(RELOCK_CYC - 1);
  logic [RT_W-1:0] relock_timer_reg, relock_timer_next;
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_code_digits
    assign code_digits[gi] = CODE_EXT[4*gi +: 4];
  end

  // Sticky across the whole attempt so a wrong digit is not revealed before the last enter.
  assign code_bad = mismatch_reg | (dig_reg != code_digits[idx_reg]);

  always_ff @(posedge CLK or posedge BTNR) begin
    if (BTNR) begin
      state_reg        <= ST_ENTRY;
      dig_reg          <= 4'd0;
      idx_reg          <= 2'd0;
      tries_reg        <= 2'd0;
      mismatch_reg     <= 1'b0;
      lock_timer_reg   <= '0;
      unlocked_reg     <= 1'b0;
      alarm_reg        <= 1'b0;
`ifdef SAFE_LOCK_AUTORELOCK_EN
      relock_timer_reg <= '0;
`endif
    end else begin
      state_reg        <= state_next;
      dig_reg          <= dig_next;
      idx_reg          <= idx_next;
      tries_reg        <= tries_next;
      mismatch_reg     <= mismatch_next;
      lock_timer_reg   <= lock_timer_next;
      unlocked_reg     <= unlocked_next;
      alarm_reg        <= alarm_next;
`ifdef SAFE_LOCK_AUTORELOCK_EN
      relock_timer_reg <= relock_timer_next;
`endif
    end
  end

  always_comb begin
    state_next        = state_reg;
    dig_next          = dig_reg;
    idx_next          = idx_reg;
    tries_next        = tries_reg;
    mismatch_next     = mismatch_reg;
    lock_timer_next   = lock_timer_reg;
`ifdef SAFE_LOCK_AUTORELOCK_EN
    relock_timer_next = relock_timer_reg;
`endif
    case (state_reg)
      ST_ENTRY: begin
        // enter has priority; a simultaneous step is dropped.
        if (enter) begin
          dig_next = 4'd0;
          if (idx_reg != LAST_IDX) begin
            idx_next      = idx_reg + 2'd1;
            mismatch_next = code_bad;
          end else begin
            idx_next      = 2'd0;
            mismatch_next = 1'b0;
            if (!code_bad) begin
              state_next = ST_OPEN;
              tries_next = 2'd0;
`ifdef SAFE_LOCK_AUTORELOCK_EN
              relock_timer_next = RT_LOAD;
`endif
            end else if ({1'b0, tries_reg} + 3'd1 < MAX_T3) begin
              tries_next = tries_reg + 2'd1;
            end else begin
              state_next      = ST_LOCKOUT;
              tries_next      = MAX_T;
              lock_timer_next = LT_LOAD;
            end
          end
        end else if (step) begin
          dig_next = (dig_reg == 4'd9) ? 4'd0 : dig_reg + 4'd1;
        end
      end
      ST_OPEN: begin
        if (lock) begin
          state_next = ST_ENTRY;
          dig_next   = 4'd0;
          idx_next   = 2'd0;
`ifdef SAFE_LOCK_AUTORELOCK_EN
          relock_timer_next = '0;
        end else if (relock_timer_reg == '0) begin
          state_next = ST_ENTRY;
          dig_next   = 4'd0;
          idx_next   = 2'd0;
          tries_next = 2'd0;
        end else begin
          relock_timer_next = relock_timer_reg - 1'b1;
`endif
        end
      end
      ST_LOCKOUT: begin
        if (lock_timer_reg == '0) begin
          state_next = ST_ENTRY;
          tries_next = 2'd0;
        end else begin
          lock_timer_next = lock_timer_reg - 1'b1;
        end
      end
      default: begin
        state_next = ST_ENTRY;
      end
    endcase
  end

  always_comb begin
    unlocked_next = (state_next == ST_OPEN);
    alarm_next    = (state_next == ST_LOCKOUT);
  end

  assign dig      = dig_reg;
  assign idx      = idx_reg;
  assign tries    = tries_reg;
  assign state    = state_reg;
  assign unlocked = unlocked_reg;
  assign alarm    = alarm_reg;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Scoreboard bench for safe_lock_ctrl (LOCKOUT_CYC=20, RELOCK_CYC=10); honours SAFE_LOCK_AUTORELOCK_EN.
module tb_safe_lock_ctrl;

  logic       CLK = 1'b0;
  logic       BTNR = 1'b1;
  logic       step = 1'b0, enter = 1'b0, lock = 1'b0;
  logic [3:0] dig;
  logic [1:0] idx, tries, state;
  logic       unlocked, alarm;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string      name;
    int         cyc;
    logic [11:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  safe_lock_ctrl #(
    .LOCKOUT_CYC(20),
    .RELOCK_CYC (10)
  ) dut (
    .CLK     (CLK),
    .BTNR    (BTNR),
    .step    (step),
    .enter   (enter),
    .lock    (lock),
    .dig     (dig),
    .idx     (idx),
    .tries   (tries),
    .state   (state),
    .unlocked(unlocked),
    .alarm   (alarm)
  );

  wire [11:0] act = {dig, idx, tries, state, unlocked, alarm};

  function automatic logic [11:0] ov(int d, int i, int t, int s, int u, int a);
    return {4'(d), 2'(i), 2'(t), 2'(s), 1'(u), 1'(a)};
  endfunction

  function automatic void check(string name, logic [11:0] a, logic [11:0] e);
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      $display("FAIL %s: got dig=%0d idx=%0d tries=%0d state=%0d unl=%0d alarm=%0d, expected dig=%0d idx=%0d tries=%0d state=%0d unl=%0d alarm=%0d",
               name, a[11:8], a[7:6], a[5:4], a[3:2], a[1], a[0],
               e[11:8], e[7:6], e[5:4], e[3:2], e[1], e[0]);
    end else begin
      $display("[TB] ok %s: dig=%0d idx=%0d tries=%0d state=%0d unl=%0d alarm=%0d",
               name, a[11:8], a[7:6], a[5:4], a[3:2], a[1], a[0]);
    end
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: compare every expectation due in the current cycle, away from the active edge.
  initial forever begin
    @(negedge CLK);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, act, e.v);
    end
  end

  task automatic expect_now(input string name, input logic [11:0] v);
    sb.push_back('{name, cyc, v});
  endtask

  task automatic cyc1(input logic s, input logic e, input logic l);
    step = s; enter = e; lock = l;
    @(posedge CLK); #1;
    step = 1'b0; enter = 1'b0; lock = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc1(1'b0, 1'b0, 1'b0);
  endtask

  task automatic digit(input int d);
    repeat (d) cyc1(1'b1, 1'b0, 1'b0);
    cyc1(1'b0, 1'b1, 1'b0);
  endtask

  task automatic code3(input int a, input int b, input int c);
    digit(a); digit(b); digit(c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    BTNR = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    BTNR = 1'b0;
    expect_now("reset_state", ov(0,0,0,0,0,0));

    // Correct code 3,5,7
    repeat (3) cyc1(1'b1, 1'b0, 1'b0);
    expect_now("steps_to_3", ov(3,0,0,0,0,0));
    cyc1(1'b0, 1'b1, 1'b0);
    expect_now("commit_d0", ov(0,1,0,0,0,0));
    digit(5);
    expect_now("commit_d1", ov(0,2,0,0,0,0));
    digit(7);
    expect_now("open", ov(0,0,0,1,1,0));
    cyc1(1'b1, 1'b1, 1'b0);
    expect_now("open_ignores_keys", ov(0,0,0,1,1,0));
    cyc1(1'b0, 1'b0, 1'b1);
    expect_now("relock", ov(0,0,0,0,0,0));

    // Wrong codes increment tries; lock in ENTRY has no effect; success clears tries
    code3(3, 5, 6);
    expect_now("wrong_356", ov(0,0,1,0,0,0));
    code3(0, 0, 0);
    expect_now("wrong_000", ov(0,0,2,0,0,0));
    repeat (3) cyc1(1'b1, 1'b0, 1'b0);
    cyc1(1'b0, 1'b0, 1'b1);
    expect_now("lock_in_entry", ov(3,0,2,0,0,0));
    cyc1(1'b0, 1'b1, 1'b0);
    digit(5);
    digit(7);
    expect_now("open_clears_tries", ov(0,0,0,1,1,0));
    cyc1(1'b0, 1'b0, 1'b1);
    expect_now("relock2", ov(0,0,0,0,0,0));

    // Three wrong codes -> lockout for exactly 20 cycles
    code3(0, 0, 0);
    expect_now("try1", ov(0,0,1,0,0,0));
    code3(1, 1, 1);
    expect_now("try2", ov(0,0,2,0,0,0));
    code3(9, 9, 9);
    expect_now("lockout_entry", ov(0,0,3,2,0,1));
    cyc1(1'b1, 1'b0, 1'b0);
    expect_now("lockout_step", ov(0,0,3,2,0,1));
    cyc1(1'b0, 1'b1, 1'b0);
    expect_now("lockout_enter", ov(0,0,3,2,0,1));
    cyc1(1'b0, 1'b0, 1'b1);
    expect_now("lockout_lock", ov(0,0,3,2,0,1));
    idle(15);
    expect_now("alarm_cycle19", ov(0,0,3,2,0,1));
    idle(1);
    expect_now("alarm_cycle20", ov(0,0,3,2,0,1));
    idle(1);
    expect_now("lockout_expired", ov(0,0,0,0,0,0));

    // Decimal wrap and step+enter collision
    repeat (9) cyc1(1'b1, 1'b0, 1'b0);
    expect_now("dig_9", ov(9,0,0,0,0,0));
    cyc1(1'b1, 1'b0, 1'b0);
    expect_now("dig_wrap", ov(0,0,0,0,0,0));
    repeat (2) cyc1(1'b1, 1'b0, 1'b0);
    cyc1(1'b1, 1'b1, 1'b0);
    expect_now("step_enter", ov(0,1,0,0,0,0));
    digit(5);
    digit(7);
    expect_now("committed_2_wrong", ov(0,0,1,0,0,0));
    repeat (3) cyc1(1'b1, 1'b0, 1'b0);
    cyc1(1'b1, 1'b1, 1'b0);
    digit(5);
    digit(7);
    expect_now("committed_3_open", ov(0,0,0,1,1,0));

`ifdef SAFE_LOCK_AUTORELOCK_EN
    idle(9);
    expect_now("open_cycle9", ov(0,0,0,1,1,0));
    idle(1);
    expect_now("auto_relock", ov(0,0,0,0,0,0));
    code3(3, 5, 7);
    expect_now("reopen", ov(0,0,0,1,1,0));
    idle(4);
    cyc1(1'b0, 1'b0, 1'b1);
    expect_now("manual_relock", ov(0,0,0,0,0,0));
    idle(12);
    expect_now("stays_entry", ov(0,0,0,0,0,0));
`else
    idle(1000);
    expect_now("open_persists", ov(0,0,0,1,1,0));
    cyc1(1'b0, 1'b0, 1'b1);
    expect_now("manual_relock", ov(0,0,0,0,0,0));
`endif

    // Asynchronous reset in the middle of a lockout
    code3(0, 0, 0);
    code3(0, 0, 0);
    code3(0, 0, 0);
    expect_now("lockout_again", ov(0,0,3,2,0,1));
    idle(3);
    #2;
    BTNR = 1'b1;
    #1;
    check("async_reset", act, ov(0,0,0,0,0,0));
    @(posedge CLK); #1;
    BTNR = 1'b0;
    repeat (4) cyc1(1'b1, 1'b0, 1'b0);
    expect_now("after_reset_entry", ov(4,0,0,0,0,0));
    cyc1(1'b0, 1'b0, 1'b1);
    repeat (9) cyc1(1'b1, 1'b0, 1'b0);
    cyc1(1'b0, 1'b1, 1'b0);
    digit(5);
    digit(7);
    expect_now("after_reset_open", ov(0,0,0,1,1,0));

    idle(2);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
